uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- ASCII monitor command decoder on the UART receive path; the inverse of the hex-dump encoder on the transmit path.
- Consumes received characters (rx_char/rx_char_en, driven from the UART interface rout/rout_en) and parses line commands with hex arguments.
- Issues memory write, memory read and CPU run/stop/step controls, plus a CR/LF echo request toward the transmit side (crlf_in).

Parameters:
- ADDR_W, 16, width of cmd_addr; low ADDR_W bits of the address accumulator.
- DATA_W, 32, width of cmd_wdata and of each hex accumulator (max 8 hex digits).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_char  in  8  received ASCII character
- rx_char_en  in  1  one-cycle strobe, rx_char valid
- cmd_addr  out  ADDR_W  command address, held until next command
- cmd_wdata  out  DATA_W  write data, held until next command
- cmd_wr  out  1  one-cycle write pulse
- cmd_rd  out  1  one-cycle read request pulse (starts readback send)
- cpu_run  out  1  level, CPU run enable
- cpu_step  out  1  one-cycle single-step pulse
- crlf_req  out  1  one-cycle newline-echo request
- cmd_err  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0, opcode NONE.
- Character classes: hex digit 0-9 a-f A-F; space 0x20; CR 0x0d; LF 0x0a (always ignored); command letters w r g q s (lower case only); anything else is illegal.
- Hex accumulation: acc <= {acc[DATA_W-5:0], nibble}; over 8 digits, the oldest digits shift out (last 8 digits win). Digit count saturates at 1 ("has digits" flag).
- States:
  - IDLE: letter -> latch opcode, go to CMD. Space ignored. CR -> crlf_req pulse, stay. Hex or illegal -> ERR.
  - CMD: space -> ARG1. CR -> EXEC check. Anything else -> ERR.
  - ARG1: hex -> acc1. Space after at least one digit: w goes to ARG2; any other opcode goes to ERR. Extra spaces before the first digit are ignored. CR -> EXEC check. Illegal or letter -> ERR.
  - ARG2: hex -> acc2. CR -> EXEC check. Space or other -> ERR.
  - ERR: discard characters until CR; on CR pulse cmd_err, go to IDLE.
- EXEC check, combinational on the CR strobe. Outputs are registered, so they appear one clk after the CR rx_char_en; state returns to IDLE on the same edge.
  - w: needs arg1 and arg2 digits. cmd_addr <= acc1[ADDR_W-1:0], cmd_wdata <= acc2, pulse cmd_wr and crlf_req.
  - r: needs arg1 only. cmd_addr <= acc1, pulse cmd_rd. No crlf_req; the readback line supplies CR/LF.
  - g: no args. cpu_run <= 1, pulse crlf_req.
  - q: no args. cpu_run <= 0, pulse crlf_req.
  - s: no args and cpu_run == 0. Pulse cpu_step and crlf_req.
  - Any rule violated (missing or extra args, s while running): pulse cmd_err only.
- cmd_err and crlf_req are never asserted together, except through the error path, which pulses cmd_err only.
- Accumulators, digit flags and opcode clear on every return to IDLE.
- rx_char_en with no state change needed costs no cycles. The back-to-back strobe minimum is 1 cycle apart; no character is dropped.
- Asserting rst_n mid-line aborts the command. cpu_run clears.

Decomposition:
- Shared package (monitor_pkg): ASCII constants (CR, LF, SP, opcode letters), state encoding (IDLE, CMD, ARG1, ARG2, ERR), opcode encoding.
- One sub-module, hex_char_decode: combinational 8-bit ASCII to {is_hex, nibble[3:0]}. It mirrors the transmit-side nibble encoder.

Test Plan:
- "w 1a2 DEADbeef" CR -> one clk later cmd_wr=1 for 1 cycle, cmd_addr=16'h01a2, cmd_wdata=32'hdeadbeef, crlf_req=1; cmd_err=0.
- "r 123456789" CR -> cmd_rd pulse, cmd_addr=16'h6789 (acc1=32'h23456789, oldest digit dropped), crlf_req=0.
- "g" CR, then "s" CR, then "q" CR, then "s" CR:
  - g: cpu_run=1 with crlf_req.
  - first s: cmd_err pulse, no cpu_step.
  - q: cpu_run=0.
  - second s: cpu_step pulse plus crlf_req.
- Error paths:
  - "w 10" CR -> cmd_err only, no cmd_wr.
  - "x 5" CR -> cmd_err once, at the CR.
  - "r 1z3" CR -> cmd_err. The following "r 40" CR decodes cleanly to cmd_addr=16'h0040.
- Bare CR and bare LF:
  - CR in IDLE -> crlf_req pulse only.
  - LF anywhere -> no effect.
  - Back-to-back rx_char_en on consecutive cycles for "r 5" CR -> cmd_rd, cmd_addr=5.
- rst_n low while in ARG2 with cpu_run=1 -> all outputs 0 immediately. The next "r 7" CR decodes normally.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared definitions for the ASCII monitor command path.
// Holds the ASCII constants, the decoder state encoding, the opcode encoding
// and a helper that maps a command letter to its opcode.
package monitor_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_W  = 8'h77;
    localparam logic [7:0] ASCII_R  = 8'h72;
    localparam logic [7:0] ASCII_G  = 8'h67;
    localparam logic [7:0] ASCII_Q  = 8'h71;
    localparam logic [7:0] ASCII_S  = 8'h73;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ARG1 = 3'd2,
        ST_ARG2 = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_W    = 3'd1,
        OP_R    = 3'd2,
        OP_G    = 3'd3,
        OP_Q    = 3'd4,
        OP_S    = 3'd5
    } opcode_t;

    // Command letters are lower case only; anything else maps to OP_NONE.
    function automatic opcode_t char_to_op(input logic [7:0] ch);
        opcode_t op;
        case (ch)
            ASCII_W: op = OP_W;
            ASCII_R: op = OP_R;
            ASCII_G: op = OP_G;
            ASCII_Q: op = OP_Q;
            ASCII_S: op = OP_S;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII hex digit decoder (inverse of the transmit-side nibble
// encoder).
// Ports:
//   ch      in  8  ASCII character
//   is_hex  out 1  ch is 0-9, a-f or A-F
//   nibble  out 4  value of the digit (0 when not hex)
module hex_char_decode
    import monitor_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Range-classify the character; letters use low nibble + 9 ('a'/'A' -> 1 + 9).
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if ((ch >= 8'h30) && (ch <= 8'h39)) begin
            is_hex = 1'b1;
            nibble = ch[3:0];
        end else if (((ch >= 8'h61) && (ch <= 8'h66)) ||
                     ((ch >= 8'h41) && (ch <= 8'h46))) begin
            is_hex = 1'b1;
            nibble = ch[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
            nibble = 4'd0;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII monitor command decoder on the UART receive path.
// Parses "w addr data", "r addr", "g", "q", "s" lines terminated by CR and
// issues memory/CPU controls plus a newline-echo request.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rx_char, rx_char_en   received character and its one-cycle strobe
//   cmd_addr, cmd_wdata   command address / write data, held until next command
//   cmd_wr, cmd_rd        one-cycle write / read-request pulses
//   cpu_run               CPU run enable level
//   cpu_step              one-cycle single-step pulse
//   crlf_req              one-cycle newline-echo request
//   cmd_err               one-cycle error pulse
module uart_cmd_decoder
    import monitor_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_char,
    input  logic              rx_char_en,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_wr,
    output logic              cmd_rd,
    output logic              cpu_run,
    output logic              cpu_step,
    output logic              crlf_req,
    output logic              cmd_err
);

    state_t            state_r;
    opcode_t           op_r;
    logic [DATA_W-1:0] acc1_r;
    logic [DATA_W-1:0] acc2_r;
    logic              has1_r;
    logic              has2_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wr_r;
    logic              rd_r;
    logic              run_r;
    logic              step_r;
    logic              crlf_r;
    logic              err_r;

    logic              is_hex_s;
    logic [3:0]        nibble_s;
    opcode_t           char_op_s;
    logic              exec_ok_s;

    hex_char_decode u_hex (
        .ch     (rx_char),
        .is_hex (is_hex_s),
        .nibble (nibble_s)
    );

    assign char_op_s = char_to_op(rx_char);

    // Argument rules for the latched opcode, evaluated when the CR arrives.
    always_comb begin
        exec_ok_s = 1'b0;
        case (op_r)
            OP_W:    exec_ok_s = has1_r & has2_r;
            OP_R:    exec_ok_s = has1_r & ~has2_r;
            OP_G:    exec_ok_s = ~has1_r & ~has2_r;
            OP_Q:    exec_ok_s = ~has1_r & ~has2_r;
            OP_S:    exec_ok_s = ~has1_r & ~has2_r & ~run_r;
            default: exec_ok_s = 1'b0;
        endcase
    end

    // Line parser FSM with registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NONE;
            acc1_r  <= '0;
            acc2_r  <= '0;
            has1_r  <= 1'b0;
            has2_r  <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
            run_r   <= 1'b0;
            step_r  <= 1'b0;
            crlf_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            wr_r   <= 1'b0;
            rd_r   <= 1'b0;
            step_r <= 1'b0;
            crlf_r <= 1'b0;
            err_r  <= 1'b0;
            // LF is ignored everywhere so CR/LF and bare CR line endings both work.
            if (rx_char_en && (rx_char != ASCII_LF)) begin
                if (rx_char == ASCII_CR) begin
                    if (state_r == ST_IDLE) begin
                        crlf_r <= 1'b1;
                    end else if (state_r == ST_ERR) begin
                        err_r <= 1'b1;
                    end else if (exec_ok_s) begin
                        case (op_r)
                            OP_W: begin
                                addr_r  <= acc1_r[ADDR_W-1:0];
                                wdata_r <= acc2_r;
                                wr_r    <= 1'b1;
                                crlf_r  <= 1'b1;
                            end
                            OP_R: begin
                                // Readback line supplies its own CR/LF.
                                addr_r <= acc1_r[ADDR_W-1:0];
                                rd_r   <= 1'b1;
                            end
                            OP_G: begin
                                run_r  <= 1'b1;
                                crlf_r <= 1'b1;
                            end
                            OP_Q: begin
                                run_r  <= 1'b0;
                                crlf_r <= 1'b1;
                            end
                            OP_S: begin
                                step_r <= 1'b1;
                                crlf_r <= 1'b1;
                            end
                            default: err_r <= 1'b1;
                        endcase
                    end else begin
                        err_r <= 1'b1;
                    end
                    // Every CR ends the line: back to a clean IDLE.
                    state_r <= ST_IDLE;
                    op_r    <= OP_NONE;
                    acc1_r  <= '0;
                    acc2_r  <= '0;
                    has1_r  <= 1'b0;
                    has2_r  <= 1'b0;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            if (char_op_s != OP_NONE) begin
                                op_r    <= char_op_s;
                                state_r <= ST_CMD;
                            end else if (rx_char != ASCII_SP) begin
                                state_r <= ST_ERR;
                            end
                        end
                        ST_CMD: begin
                            state_r <= (rx_char == ASCII_SP) ? ST_ARG1 : ST_ERR;
                        end
                        ST_ARG1: begin
                            if (is_hex_s) begin
                                // Oldest digit shifts out: the last 8 digits win.
                                acc1_r <= {acc1_r[DATA_W-5:0], nibble_s};
                                has1_r <= 1'b1;
                            end else if (rx_char == ASCII_SP) begin
                                // Leading spaces are ignored; a separator is only legal for w.
                                if (has1_r) begin
                                    state_r <= (op_r == OP_W) ? ST_ARG2 : ST_ERR;
                                end
                            end else begin
                                state_r <= ST_ERR;
                            end
                        end
                        ST_ARG2: begin
                            if (is_hex_s) begin
                                acc2_r <= {acc2_r[DATA_W-5:0], nibble_s};
                                has2_r <= 1'b1;
                            end else begin
                                state_r <= ST_ERR;
                            end
                        end
                        ST_ERR: begin
                            state_r <= ST_ERR;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign cmd_addr  = addr_r;
    assign cmd_wdata = wdata_r;
    assign cmd_wr    = wr_r;
    assign cmd_rd    = rd_r;
    assign cpu_run   = run_r;
    assign cpu_step  = step_r;
    assign crlf_req  = crlf_r;
    assign cmd_err   = err_r;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder.
module tb_uart_cmd_decoder;

    localparam logic [7:0] CR = 8'h0d;
    localparam logic [7:0] LF = 8'h0a;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_char;
    logic        rx_char_en;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_wr;
    logic        cmd_rd;
    logic        cpu_run;
    logic        cpu_step;
    logic        crlf_req;
    logic        cmd_err;

    int n_cmp;
    int n_mis;

    uart_cmd_decoder #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_char    (rx_char),
        .rx_char_en (rx_char_en),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wr     (cmd_wr),
        .cmd_rd     (cmd_rd),
        .cpu_run    (cpu_run),
        .cpu_step   (cpu_step),
        .crlf_req   (crlf_req),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One strobed character; returns on the negedge after the sampling posedge,
    // so registered results of this character are visible on return.
    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        rx_char    = c;
        rx_char_en = 1'b1;
        @(negedge clk);
        rx_char_en = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_char(CR);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic check_pulses(input string tag, input logic [4:0] exp);
        check_eq(tag, {27'd0, cmd_wr, cmd_rd, cpu_step, crlf_req, cmd_err}, {27'd0, exp});
    endtask

    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        rst_n      = 1'b0;
        rx_char    = 8'h00;
        rx_char_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_addr", {16'd0, cmd_addr}, 32'h0);
        check_eq("reset_wdata", cmd_wdata, 32'h0);
        check_eq("reset_run", {31'd0, cpu_run}, 32'h0);
        check_pulses("reset_pulses", 5'b00000);
        rst_n = 1'b1;
        idle_cycle();

        // pulses field order: {wr, rd, step, crlf, err}
        send_line("w 1a2 DEADbeef");
        check_pulses("w_pulses", 5'b10010);
        check_eq("w_addr", {16'd0, cmd_addr}, 32'h0000_01a2);
        check_eq("w_wdata", cmd_wdata, 32'hdeadbeef);
        idle_cycle();
        check_pulses("w_pulse_len", 5'b00000);
        check_eq("w_wdata_held", cmd_wdata, 32'hdeadbeef);

        send_line("r 123456789");
        check_pulses("r9_pulses", 5'b01000);
        check_eq("r9_addr", {16'd0, cmd_addr}, 32'h0000_6789);

        send_line("g");
        check_pulses("g_pulses", 5'b00010);
        check_eq("g_run", {31'd0, cpu_run}, 32'h1);
        send_line("s");
        check_pulses("s_running_pulses", 5'b00001);
        check_eq("s_running_run", {31'd0, cpu_run}, 32'h1);
        send_line("q");
        check_pulses("q_pulses", 5'b00010);
        check_eq("q_run", {31'd0, cpu_run}, 32'h0);
        send_line("s");
        check_pulses("s_stopped_pulses", 5'b00110);

        send_line("w 10");
        check_pulses("w_missing_arg", 5'b00001);
        check_eq("w_missing_addr_held", {16'd0, cmd_addr}, 32'h0000_6789);

        send_str("x 5");
        check_pulses("x_before_cr", 5'b00000);
        send_char(CR);
        check_pulses("x_at_cr", 5'b00001);
        idle_cycle();
        check_pulses("x_once", 5'b00000);

        send_line("r 1z3");
        check_pulses("r_badhex", 5'b00001);
        send_line("r 40");
        check_pulses("r40_pulses", 5'b01000);
        check_eq("r40_addr", {16'd0, cmd_addr}, 32'h0000_0040);

        send_line("r 5 6");
        check_pulses("r_extra_arg", 5'b00001);

        send_char(CR);
        check_pulses("bare_cr", 5'b00010);
        send_char(LF);
        check_pulses("bare_lf", 5'b00000);
        send_str("r 4");
        send_char(LF);
        send_line("2");
        check_pulses("lf_midline_pulses", 5'b01000);
        check_eq("lf_midline_addr", {16'd0, cmd_addr}, 32'h0000_0042);

        // Back-to-back strobes on consecutive cycles.
        @(negedge clk);
        rx_char_en = 1'b1;
        rx_char = "r";
        @(negedge clk);
        rx_char = " ";
        @(negedge clk);
        rx_char = "5";
        @(negedge clk);
        rx_char = CR;
        @(negedge clk);
        rx_char_en = 1'b0;
        check_pulses("b2b_pulses", 5'b01000);
        check_eq("b2b_addr", {16'd0, cmd_addr}, 32'h0000_0005);

        // Asynchronous reset mid-line in ARG2 while running.
        send_line("g");
        check_eq("pre_rst_run", {31'd0, cpu_run}, 32'h1);
        send_str("w 1 2");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_run", {31'd0, cpu_run}, 32'h0);
        check_eq("rst_addr", {16'd0, cmd_addr}, 32'h0);
        check_eq("rst_wdata", cmd_wdata, 32'h0);
        check_pulses("rst_pulses", 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        send_line("r 7");
        check_pulses("post_rst_pulses", 5'b01000);
        check_eq("post_rst_addr", {16'd0, cmd_addr}, 32'h0000_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
